// File: rtl/bcd_pkg.sv
// Shared types, constants and helpers for the BCD countdown timer.
// Optional feature macro used by the top level: AUTO_RELOAD_EN.
package bcd_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // Saturate a nibble to a legal BCD digit; codes A..F become 9.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control/status bundle for bcd_countdown_timer.
// master: the block that drives load/start/pause/tick and watches the count.
// slave : the timer itself.
interface bcd_countdown_timer_if #(
  parameter int DIGITS = 2
);

  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic                  start;
  logic                  pause;
  logic                  tick;
  logic [4*DIGITS-1:0]   count;
  logic                  busy;
  logic                  done;

  modport master (
    output load, load_value, start, pause, tick,
    input  count, busy, done
  );

  modport slave (
    input  load, load_value, start, pause, tick,
    output count, busy, done
  );

endinterface

// File: rtl/bcd_digit_down.sv
// One BCD digit of the down-counter. Loads a preset digit, or decrements
// 9..0 with 0 wrapping to 9. borrow_out_o flags a digit sitting at zero, so
// the next digit up must decrement whenever this one is asked to.
module bcd_digit_down
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [3:0] load_digit_i,
  input  logic       dec_i,
  output logic [3:0] digit_o,
  output logic       borrow_out_o
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  // Next digit value: load wins over decrement.
  always_comb begin
    // NOTE: default assigned first so every path drives digit_d and no latch is inferred.
    digit_d = digit_q;
    if (load_i) begin
      digit_d = load_digit_i;
    end else if (dec_i) begin
      digit_d = (digit_q == BCD_ZERO) ? BCD_MAX : (digit_q - 4'd1);
    end
  end

  // Digit register, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments in clocked blocks so all registers update together at the edge.
    if (!reset) begin
      digit_q <= BCD_ZERO;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o      = digit_q;
  assign borrow_out_o = (digit_q == BCD_ZERO);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Loadable multi-digit BCD down-counter / timer.
// Counts a preset down to zero, one step per tick while running, and pulses
// done for one cycle on the terminal count.
// Build option: define AUTO_RELOAD_EN to reload the preset on the terminal
// tick and keep running (periodic timer). Undefined gives one-shot operation.
module bcd_countdown_timer
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  bcd_countdown_timer_if.slave    bus_if
);

  localparam int              W          = 4 * DIGITS;
  localparam logic [W-1:0]    COUNT_ONE  = W'(1);

  state_e           state_q;
  state_e           state_d;
  logic             busy_q;
  logic             busy_d;
  logic             done_q;
  logic             done_d;

  logic [W-1:0]     load_clamped;
  logic [W-1:0]     load_word;
  logic [W-1:0]     count;
  logic             digit_load;
  logic             dec_en;
  logic [DIGITS-1:0] digit_zero;
  logic [DIGITS-1:0] digit_dec;
  logic             count_is_zero;
  logic             count_is_one;

`ifdef AUTO_RELOAD_EN
  logic [W-1:0]     reload_q;
  logic [W-1:0]     reload_d;
`endif

  // Digit chain: digit g decrements when the count steps and every lower
  // digit is at zero (i.e. is about to wrap to 9 and borrow).
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign load_clamped[4*g +: 4] = bcd_clamp(bus_if.load_value[4*g +: 4]);

    if (g == 0) begin : g_lsd
      assign digit_dec[g] = dec_en;
    end else begin : g_upper
      assign digit_dec[g] = digit_dec[g-1] & digit_zero[g-1];
    end

    bcd_digit_down u_digit (
      .clk          (clk),
      .reset        (reset),
      .load_i       (digit_load),
      .load_digit_i (load_word[4*g +: 4]),
      .dec_i        (digit_dec[g]),
      .digit_o      (count[4*g +: 4]),
      .borrow_out_o (digit_zero[g])
    );
  end

  assign count_is_zero = &digit_zero;
  assign count_is_one  = (count == COUNT_ONE);

  // Next-state, digit load/decrement and done/busy next values.
  // Priority each cycle: load > start > pause > tick.
  always_comb begin
    state_d    = state_q;
    digit_load = 1'b0;
    load_word  = load_clamped;
    dec_en     = 1'b0;
    done_d     = 1'b0;

    if (bus_if.load) begin
      // Load aborts anything in flight, including a coinciding terminal tick.
      state_d    = ST_IDLE;
      digit_load = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Starting from zero would finish instantly; it is ignored instead.
          if (bus_if.start && !count_is_zero) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          // start has no effect while running.
          if (bus_if.pause) begin
            state_d = ST_HOLD;
          end else if (bus_if.tick) begin
            if (count_is_one) begin
              done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
              // Periodic mode: restart from the preset and stay running. A
              // zero preset cannot restart, so it falls back to one-shot.
              if (reload_q != '0) begin
                digit_load = 1'b1;
                load_word  = reload_q;
              end else begin
                dec_en  = 1'b1;
                state_d = ST_DONE;
              end
`else
              dec_en  = 1'b1;
              state_d = ST_DONE;
`endif
            end else if (!count_is_zero) begin
              // Guarded so the count can never wrap below zero.
              dec_en = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (bus_if.start) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
  end

  // State, busy and done registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef AUTO_RELOAD_EN
  // Reload register follows every load with the same sanitised value.
  always_comb begin
    reload_d = bus_if.load ? load_clamped : reload_q;
  end

  // Reload register storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  assign bus_if.count = count;
  assign bus_if.busy  = busy_q;
  assign bus_if.done  = done_q;

endmodule
